// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one combinational addsub32 among N requesters.
// Optional ADDSUB_STATS_EN adds op_count/ovf_count statistics outputs.

module addsub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] ans,
    output logic        cout,
    output logic        v
);
    logic [31:0] bx;
    logic [31:0] lo;
    logic [1:0]  hi;

    // Split at bit 31 so the carry into the sign bit is visible for overflow.
    always_comb begin
        bx   = b ^ {32{sub}};
        lo   = {1'b0, a[30:0]} + {1'b0, bx[30:0]} + {31'd0, sub};
        hi   = {1'b0, a[31]} + {1'b0, bx[31]} + {1'b0, lo[31]};
        ans  = {hi[0], lo[30:0]};
        cout = hi[1];
        v    = lo[31] ^ hi[1];
    end
endmodule

module addsub_arbiter #(
    parameter int N             = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0][31:0]  a_in,
    input  logic [N-1:0][31:0]  b_in,
    input  logic [N-1:0]        sub_in,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        done,
    output logic [31:0]         result,
    output logic                cout_out,
    output logic                v_out,
`ifdef ADDSUB_STATS_EN
    output logic [15:0]         op_count,
    output logic [15:0]         ovf_count,
`endif
    output logic                busy
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
    } op_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr, sel, idx;
    logic [CW-1:0]   cnt;
    op_t             op_q;
    logic            found, grant, capture;
    logic [31:0]     ans;
    logic            ans_c, ans_v;

    addsub32 u_addsub (
        .a    (op_q.a),
        .b    (op_q.b),
        .sub  (op_q.sub),
        .ans  (ans),
        .cout (ans_c),
        .v    (ans_v)
    );

    // First requester after rr_ptr wins; the last-served port is checked last.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(rr_ptr) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                grant   = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: if (cnt == '0) begin
                capture = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            gnt      <= '0;
            done     <= '0;
            rr_ptr   <= PW'(N - 1);
            cnt      <= '0;
            result   <= '0;
            cout_out <= 1'b0;
            v_out    <= 1'b0;
        end else begin
            if (grant) begin
                op_q   <= '{a: a_in[sel], b: b_in[sel], sub: sub_in[sel]};
                gnt    <= N'(1) << sel;
                rr_ptr <= sel;
                cnt    <= CW'(SETTLE_CYCLES - 1);
            end else if (state_q == SETTLE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                result   <= ans;
                cout_out <= ans_c;
                v_out    <= ans_v;
                done     <= gnt;
            end
            if (state_q == DONE) begin
                done <= '0;
                gnt  <= '0;
            end
        end
    end

`ifdef ADDSUB_STATS_EN
    // v_out already holds the just-captured flag during the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count  <= '0;
            ovf_count <= '0;
        end else if (state_q == DONE) begin
            op_count <= op_count + 16'd1;
            if (v_out) ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_addsub_arbiter.sv
// Randomized + directed bench for addsub_arbiter against a cycle-level reference model.
// Build with ADDSUB_STATS_EN defined to also check the statistics counters.

module tb_addsub_arbiter;
    localparam int N      = 4;
    localparam int SETTLE = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        req = '0;
    logic [N-1:0][31:0]  a_in = '0;
    logic [N-1:0][31:0]  b_in = '0;
    logic [N-1:0]        sub_in = '0;
    logic [N-1:0]        gnt, done;
    logic [31:0]         result;
    logic                cout_out, v_out, busy;
`ifdef ADDSUB_STATS_EN
    logic [15:0]         op_count, ovf_count;
`endif

    int checks = 0;
    int errors = 0;

    addsub_arbiter #(.N(N), .SETTLE_CYCLES(SETTLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .sub_in   (sub_in),
        .gnt      (gnt),
        .done     (done),
        .result   (result),
        .cout_out (cout_out),
        .v_out    (v_out),
`ifdef ADDSUB_STATS_EN
        .op_count (op_count),
        .ovf_count(ovf_count),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic from integer semantics, not gate structure.
    function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                                   output logic [31:0] r, output bit c, output bit v);
        longint full, ss;
        if (!s) begin
            full = longint'({32'd0, a}) + longint'({32'd0, b});
            r    = full[31:0];
            c    = full[32];
            ss   = longint'($signed(a)) + longint'($signed(b));
        end else begin
            r  = a - b;
            c  = (a >= b);
            ss = longint'($signed(a)) - longint'($signed(b));
        end
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    endfunction

    // Model: tleft = edges since grant, -1 when idle.
    int          tleft, mport, last, mop, movf;
    logic [31:0] pres, mres;
    bit          pc, pv, mc, mv;

    function automatic int pick();
        for (int d = 1; d <= N; d++)
            if (req[(last + d) % N]) return (last + d) % N;
        return -1;
    endfunction

    task automatic model_reset();
        tleft = -1; mport = 0; last = N - 1;
        mres = '0; mc = 0; mv = 0; mop = 0; movf = 0;
    endtask

    task automatic model_step();
        if (tleft < 0) begin
            if (req != '0) begin
                mport = pick();
                last  = mport;
                ref_op(a_in[mport], b_in[mport], sub_in[mport], pres, pc, pv);
                tleft = 0;
            end
        end else begin
            tleft++;
            if (tleft == SETTLE) begin
                mres = pres; mc = pc; mv = pv;
            end else if (tleft > SETTLE) begin
                mop  = (mop + 1) & 16'hFFFF;
                if (mv) movf = (movf + 1) & 16'hFFFF;
                tleft = -1;
            end
        end
    endtask

    // One clock: advance model over the edge just passed, then compare at negedge.
    task automatic tick();
        logic [N-1:0] eg, ed;
        @(negedge clk);
        if (rst) model_reset();
        else     model_step();
        eg = (tleft >= 0) ? (N'(1) << mport) : '0;
        ed = (tleft == SETTLE) ? eg : '0;
        chk("gnt", gnt, eg);
        chk("done", done, ed);
        chk("busy", busy, tleft >= 0);
        chk("result", result, mres);
        chk("cout", cout_out, mc);
        chk("v", v_out, mv);
`ifdef ADDSUB_STATS_EN
        chk("op_count", op_count, mop);
        chk("ovf_count", ovf_count, movf);
`endif
    endtask

    task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b, input bit s,
                          input logic [31:0] er, input bit ec, input bit ev);
        int n;
        bit got;
        req[p] = 1'b1; a_in[p] = a; b_in[p] = b; sub_in[p] = s;
        n = 0; got = 0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (done != '0) got = 1;
        end
        chk("latency", n, SETTLE + 1);
        chk("op_done", done, N'(1) << p);
        chk("op_result", result, er);
        chk("op_cout", cout_out, ec);
        chk("op_v", v_out, ev);
        req[p] = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        int k, cyc, prev, obs, n;
        bit got;

        // Reset state
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        rst = 1'b0;

        // Directed arithmetic
        run_op(0, 32'd5, 32'd3, 1'b0, 32'h00000008, 1'b0, 1'b0);
        run_op(1, 32'd3, 32'd5, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op(2, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op(3, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h00000000, 1'b1, 1'b0);
`ifdef ADDSUB_STATS_EN
        chk("stats_ops", op_count, 4);
        chk("stats_ovf", ovf_count, 1);
`endif

        // All ports requesting continuously from reset
        rst = 1'b1;
        for (int p = 0; p < N; p++) begin
            a_in[p] = $urandom; b_in[p] = $urandom; sub_in[p] = $urandom_range(0, 1);
        end
        req = '1;
        tick();
        rst = 1'b0;
        k = 0; cyc = 0; prev = 0;
        while (k < 5 && cyc < 40) begin
            tick();
            cyc++;
            if (done != '0) begin
                obs = -1;
                for (int p = 0; p < N; p++) if (done[p]) obs = p;
                chk("rr_order", obs, rr_exp[k]);
                if (k > 0) chk("rr_gap", cyc - prev, SETTLE + 2);
                prev = cyc;
                k++;
            end
        end
        chk("rr_count", k, 5);

        // Reset in the middle of SETTLE aborts, then port 0 is regranted
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        req[0] = 1'b1; a_in[0] = 32'd100; b_in[0] = 32'd1; sub_in[0] = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        rst = 1'b0;
        n = 0; got = 0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (done != '0) got = 1;
        end
        chk("regrant_done", done, 1);
        chk("regrant_result", result, 32'd99);
        req = '0;
        tick();

        // Randomized traffic; the granted port may scramble operands mid-op
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int p = 0; p < N; p++) begin
                if (tleft == SETTLE && p == mport) begin
                    if ($urandom_range(0, 1) == 0) req[p] = 1'b0;
                    a_in[p] = rnd32(); b_in[p] = rnd32(); sub_in[p] = $urandom_range(0, 1);
                end else if (tleft >= 0 && tleft < SETTLE && p == mport) begin
                    if ($urandom_range(0, 3) == 0) begin
                        a_in[p] = $urandom; b_in[p] = $urandom; sub_in[p] = ~sub_in[p];
                    end
                end else if (!req[p] && $urandom_range(0, 3) == 0) begin
                    a_in[p] = rnd32(); b_in[p] = rnd32(); sub_in[p] = $urandom_range(0, 1);
                    req[p] = 1'b1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
